// File: rtl/pc_sequencer.sv
// Next-PC selection and PC register: sequential, BEQ/BNE, jump, call, return.
// Return-address stack is built only when PC_SEQ_RAS_EN is defined.
module pc_sequencer #(
    parameter int unsigned PC_WIDTH = 32,
    parameter int unsigned IMM_WIDTH = 32,
    parameter int unsigned RAS_DEPTH = 4,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 branch,
    input  logic                 branch_ne,
    input  logic                 flag,
    input  logic                 jump,
    input  logic                 call,
    input  logic                 ret,
    input  logic [25:0]          jump_addr,
    input  logic [IMM_WIDTH-1:0] immediate,
    output logic [PC_WIDTH-1:0]  pc,
    output logic [PC_WIDTH-1:0]  pc_next,
    output logic                 redirect,
    output logic                 ras_overflow,
    output logic                 ras_underflow
);

    logic [PC_WIDTH-1:0] pc_plus1;
    logic [PC_WIDTH-1:0] imm_ext;
    logic [PC_WIDTH-1:0] branch_target;
    logic [PC_WIDTH-1:0] jump_target;
    logic                taken;

    assign pc_plus1 = pc + PC_WIDTH'(1);

    // Offset is resized to the PC width: sign-extend when narrower, truncate when wider.
    generate
        if (IMM_WIDTH > PC_WIDTH) begin : g_imm_trunc
            logic [IMM_WIDTH-PC_WIDTH-1:0] unused_imm_high;
            assign unused_imm_high = immediate[IMM_WIDTH-1:PC_WIDTH];
            assign imm_ext = immediate[PC_WIDTH-1:0];
        end else if (IMM_WIDTH == PC_WIDTH) begin : g_imm_same
            assign imm_ext = immediate;
        end else begin : g_imm_sext
            assign imm_ext = {{(PC_WIDTH-IMM_WIDTH){immediate[IMM_WIDTH-1]}}, immediate};
        end
    endgenerate

    assign branch_target = pc_plus1 + imm_ext;
    assign jump_target   = {pc_plus1[PC_WIDTH-1:26], jump_addr};
    assign taken         = (branch & flag) | (branch_ne & ~flag);

`ifdef PC_SEQ_RAS_EN
    localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(RAS_DEPTH);

    logic [PC_WIDTH-1:0] stack [RAS_DEPTH];
    logic [PTR_W-1:0]    ptr;
    logic [PTR_W-1:0]    top_ptr;
    logic [PTR_W:0]      count;
    logic                full;
    logic                empty;
    logic                push;
    logic                pop;
    logic [PC_WIDTH-1:0] ras_top;

    // ptr is the next free slot; the top of stack sits one below it.
    assign top_ptr = ptr - PTR_W'(1);
    assign ras_top = stack[top_ptr];
    assign full    = (count == DEPTH_C);
    assign empty   = (count == '0);
    assign pop     = ~stall & ret;
    assign push    = ~stall & call & ~ret;

    always_comb begin
        pc_next  = pc_plus1;
        redirect = 1'b0;
        if (stall) begin
            pc_next = pc;
        end else if (ret) begin
            if (!empty) begin
                pc_next  = ras_top;
                redirect = 1'b1;
            end
        end else if (jump || call) begin
            pc_next  = jump_target;
            redirect = 1'b1;
        end else if (taken) begin
            pc_next  = branch_target;
            redirect = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr           <= '0;
            count         <= '0;
            ras_overflow  <= 1'b0;
            ras_underflow <= 1'b0;
        end else begin
            ras_overflow  <= push & full;
            ras_underflow <= pop & empty;
            if (pop && !empty) begin
                ptr   <= top_ptr;
                count <= count - (PTR_W+1)'(1);
            end else if (push) begin
                // When full, the slot at ptr holds the oldest entry and is overwritten.
                ptr <= ptr + PTR_W'(1);
                if (!full) begin
                    count <= count + (PTR_W+1)'(1);
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && push) begin
            stack[ptr] <= pc_plus1;
        end
    end
`else
    localparam int unsigned unused_ras_depth = RAS_DEPTH;
    logic unused_ret;
    assign unused_ret = ret;

    always_comb begin
        pc_next  = pc_plus1;
        redirect = 1'b0;
        if (stall) begin
            pc_next = pc;
        end else if (jump || call) begin
            pc_next  = jump_target;
            redirect = 1'b1;
        end else if (taken) begin
            pc_next  = branch_target;
            redirect = 1'b1;
        end
    end

    assign ras_overflow  = 1'b0;
    assign ras_underflow = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: a queue-based reference model predicts
// next PC, redirect and RAS flag pulses for both build configurations.
module tb_pc_sequencer;

`ifdef PC_SEQ_RAS_EN
    localparam bit RAS_ON = 1'b1;
`else
    localparam bit RAS_ON = 1'b0;
`endif
    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] pc;
        logic        ovf;
        logic        unf;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        branch = 1'b0;
    logic        branch_ne = 1'b0;
    logic        flag = 1'b0;
    logic        jump = 1'b0;
    logic        call = 1'b0;
    logic        ret = 1'b0;
    logic [25:0] jump_addr = '0;
    logic [31:0] immediate = '0;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic        redirect;
    logic        ras_overflow;
    logic        ras_underflow;

    int checks = 0;
    int failures = 0;

    logic [31:0] m_pc;
    logic [31:0] m_ras[$];
    exp_t        sb_q[$];

    pc_sequencer #(
        .PC_WIDTH(32),
        .IMM_WIDTH(32),
        .RAS_DEPTH(DEPTH),
        .RESET_PC(32'h0)
    ) dut (
        .clock(clock),
        .reset(reset),
        .stall(stall),
        .branch(branch),
        .branch_ne(branch_ne),
        .flag(flag),
        .jump(jump),
        .call(call),
        .ret(ret),
        .jump_addr(jump_addr),
        .immediate(immediate),
        .pc(pc),
        .pc_next(pc_next),
        .redirect(redirect),
        .ras_overflow(ras_overflow),
        .ras_underflow(ras_underflow)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic do_reset(input logic st);
        reset = 1'b1;
        stall = st;
        call = 1'b1;
        ret = 1'b1;
        jump = 1'b1;
        jump_addr = 26'h155;
        @(posedge clock);
        #1;
        reset = 1'b0;
        stall = 1'b0;
        call = 1'b0;
        ret = 1'b0;
        jump = 1'b0;
        m_pc = 32'h0;
        m_ras.delete();
        sb_q.delete();
        check("reset_pc", pc, 32'h0);
        check("reset_ovf", {31'b0, ras_overflow}, 32'h0);
        check("reset_unf", {31'b0, ras_underflow}, 32'h0);
    endtask

    task automatic drive(input logic st, input logic br, input logic bne,
                         input logic fl, input logic jp, input logic cl,
                         input logic rt, input logic [25:0] ja,
                         input logic [31:0] imm);
        exp_t        e;
        logic [31:0] p1;
        logic        rd;
        stall = st;
        branch = br;
        branch_ne = bne;
        flag = fl;
        jump = jp;
        call = cl;
        ret = rt;
        jump_addr = ja;
        immediate = imm;
        p1 = m_pc + 32'd1;
        e.pc = p1;
        e.ovf = 1'b0;
        e.unf = 1'b0;
        rd = 1'b0;
        if (st) begin
            e.pc = m_pc;
        end else if (RAS_ON && rt) begin
            if (m_ras.size() > 0) begin
                e.pc = m_ras.pop_back();
                rd = 1'b1;
            end else begin
                e.unf = 1'b1;
            end
        end else if (jp || cl) begin
            e.pc = {p1[31:26], ja};
            rd = 1'b1;
            if (RAS_ON && cl) begin
                if (m_ras.size() == DEPTH) begin
                    e.ovf = 1'b1;
                    void'(m_ras.pop_front());
                end
                m_ras.push_back(p1);
            end
        end else if ((br && fl) || (bne && !fl)) begin
            e.pc = p1 + imm;
            rd = 1'b1;
        end
        m_pc = e.pc;
        sb_q.push_back(e);
        #4;
        check("redirect", {31'b0, redirect}, {31'b0, rd});
        check("pc_next", pc_next, e.pc);
        @(posedge clock);
        #1;
        if (sb_q.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check("pc", pc, e.pc);
            check("ras_ovf", {31'b0, ras_overflow}, {31'b0, e.ovf});
            check("ras_unf", {31'b0, ras_underflow}, {31'b0, e.unf});
        end
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, '0, '0);
    endtask

    task automatic go(input logic [25:0] a);
        drive(0, 0, 0, 0, 1, 0, 0, a, '0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clock);
        #1;
        do_reset(1'b0);
        repeat (3) idle();

        go(26'd10);
        drive(0, 1, 0, 1, 0, 0, 0, '0, 32'hFFFF_FFFC);
        go(26'd10);
        drive(0, 1, 0, 0, 0, 0, 0, '0, 32'hFFFF_FFFC);
        go(26'd20);
        drive(0, 0, 1, 0, 0, 0, 0, '0, 32'd5);
        go(26'd20);
        drive(1, 1, 0, 1, 0, 0, 0, '0, 32'd7);
        drive(0, 1, 1, 1, 0, 0, 0, '0, 32'd3);

        go(26'h100);
        drive(0, 0, 0, 0, 0, 1, 0, 26'h40, '0);
        drive(0, 0, 0, 0, 0, 0, 1, '0, '0);

        do_reset(1'b0);
        drive(0, 0, 0, 0, 0, 0, 1, '0, '0);
        idle();

        do_reset(1'b0);
        idle();
        for (int i = 2; i <= 6; i++) begin
            drive(0, 0, 0, 0, 0, 1, 0, 26'(i), '0);
        end
        idle();
        go(26'd5);
        repeat (5) drive(0, 0, 0, 0, 0, 0, 1, '0, '0);
        idle();

        do_reset(1'b0);
        go(26'h2F);
        drive(0, 0, 0, 0, 0, 1, 0, 26'h50, '0);
        drive(0, 0, 0, 0, 0, 1, 1, 26'h70, '0);
        drive(0, 0, 0, 0, 0, 0, 1, '0, '0);
        drive(1, 0, 0, 0, 0, 1, 0, 26'h90, '0);

        go(26'h33);
        drive(0, 0, 0, 0, 0, 1, 0, 26'h80, '0);
        stall = 1'b1;
        do_reset(1'b1);
        drive(0, 0, 0, 0, 0, 0, 1, '0, '0);

        for (int i = 0; i < 60; i++) begin
            drive($urandom_range(0, 5) == 0,
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 3) == 0,
                  1'($urandom_range(0, 1)),
                  $urandom_range(0, 7) == 0,
                  $urandom_range(0, 4) == 0,
                  $urandom_range(0, 4) == 0,
                  26'($urandom_range(0, 4095)),
                  32'($urandom_range(0, 64)) - 32'd32);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
